// File: rtl/reg_file_if.sv
// reg_file_if: read/write/HI/overflow bus between the register file and its
// user (ALU datapath or testbench). The master drives addresses and write-back;
// the slave (reg_file) returns operands, HI and the sticky overflow flag.
interface reg_file_if;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [15:0] rs_data;
  logic [15:0] rt_data;
  logic        we;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        hi_we;
  logic [15:0] hi_data;
  logic        ovf;
  logic        ovf_clr;

  modport master (
    output rs_addr, rt_addr, we, wr_addr, wr_data, hi_we, ovf_clr,
    input  rs_data, rt_data, hi_data, ovf
  );

  modport slave (
    input  rs_addr, rt_addr, we, wr_addr, wr_data, hi_we, ovf_clr,
    output rs_data, rt_data, hi_data, ovf
  );
endinterface

// File: rtl/reg_file.sv
// reg_file: 32 x 16-bit architectural register file feeding the ALU, with a
// HI register for the upper half of multiply results and a sticky flag that
// records when a 32-bit result is truncated on write-back. R0 is hardwired 0.
// Optional macro WRITE_BYPASS_EN forwards the in-flight write to the read
// ports and HI in the same cycle (address 0 is never forwarded).
module reg_file #(
  parameter int NREGS = 32
) (
  input logic       clk,
  input logic       rst,
  reg_file_if.slave bus
);
  localparam int AW = 5;

  logic [15:0] regs [NREGS];
  logic [15:0] hi_q;
  logic        ovf_q;
  logic [15:0] rs_q;
  logic [15:0] rt_q;
  logic        wr_en;
  logic        trunc;

  // A write to R0 (or beyond the array) is dropped entirely.
  assign wr_en = bus.we && (bus.wr_addr != '0) && (int'(bus.wr_addr) < NREGS);
  // Upper half thrown away only when it is not being captured into HI.
  assign trunc = wr_en && !bus.hi_we && (bus.wr_data[31:16] != '0);

  // General register storage; reset wins over any write in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[bus.wr_addr] <= bus.wr_data[15:0];
    end
  end

  // HI captures the upper result half regardless of the general write.
  always_ff @(posedge clk) begin
    if (rst)            hi_q <= '0;
    else if (bus.hi_we) hi_q <= bus.wr_data[31:16];
  end

  // Sticky truncation flag; a set in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (rst)              ovf_q <= 1'b0;
    else if (trunc)       ovf_q <= 1'b1;
    else if (bus.ovf_clr) ovf_q <= 1'b0;
  end

  // Stored-state reads; address 0 (and anything out of range) reads zero.
  always_comb begin
    rs_q = '0;
    rt_q = '0;
    if (bus.rs_addr != '0 && int'(bus.rs_addr) < NREGS) rs_q = regs[bus.rs_addr];
    if (bus.rt_addr != '0 && int'(bus.rt_addr) < NREGS) rt_q = regs[bus.rt_addr];
  end

`ifdef WRITE_BYPASS_EN
  // wr_en already excludes address 0, so R0 is never forwarded.
  assign bus.rs_data = (wr_en && bus.rs_addr == bus.wr_addr) ? bus.wr_data[15:0] : rs_q;
  assign bus.rt_data = (wr_en && bus.rt_addr == bus.wr_addr) ? bus.wr_data[15:0] : rt_q;
  assign bus.hi_data = bus.hi_we ? bus.wr_data[31:16] : hi_q;
`else
  assign bus.rs_data = rs_q;
  assign bus.rt_data = rt_q;
  assign bus.hi_data = hi_q;
`endif

  assign bus.ovf = ovf_q;

  // Address width is fixed; keep the localparam tied to the port width.
  logic [AW-1:0] unused_aw;
  assign unused_aw = bus.wr_addr;
  logic unused_ok;
  assign unused_ok = ^unused_aw;
endmodule
